// File: rtl/decode_stage.sv
// decode_stage: buffered RV32I decode stage with valid/ready handshakes on both sides.
// Define CORE_RV32M_EN to decode RV32M multiply/divide; otherwise those encodings are illegal.
module decode_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic            reg_wen,
  output logic            reg_rs1_rd,
  output logic            reg_rs2_rd,
  output logic [4:0]      reg_waddr,
  output logic [4:0]      reg_rs1_addr,
  output logic [4:0]      reg_rs2_addr,
  output logic [31:0]     imm_value,
  output logic [3:0]      alu_op,
  output logic            sel_imm,
  output logic            op1_sel_zero,
  output logic            op1_sel_pc,
  output logic            op2_sel_4,
  output logic            br_instr,
  output logic            jal_instr,
  output logic            jalr_instr,
  output logic [2:0]      branch_op,
  output logic [2:0]      mem_op,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            csr_rd,
  output logic [1:0]      csr_wr_op,
  output logic [11:0]     csr_addr,
  output logic            mret,
  output logic            md_instr,
  output logic [2:0]      md_op,
  output logic            exc_ill_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0] instr;
    logic reg_wen, rs1_rd, rs2_rd;
    logic [4:0] waddr, rs1_addr, rs2_addr;
    logic [31:0] imm;
    logic [3:0] alu_op;
    logic sel_imm, op1_zero, op1_pc, op2_4, br, jal, jalr;
    logic [2:0] branch_op, mem_op;
    logic mem_rd, mem_wr, csr_rd;
    logic [1:0] csr_wr_op;
    logic [11:0] csr_addr;
    logic mret, md_instr;
    logic [2:0] md_op;
    logic ill;
  } bundle_t;
  logic [31:0] fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, ill;
  logic [31:0] i;
  logic [2:0] f3;
  logic [6:0] f7;
  bundle_t d, q;
  assign if_ready = count != CW'(DEPTH) && !rst;
  assign push = if_valid && if_ready;
  assign pop = count != '0 && (!id_valid || id_ready);
  assign i = fifo_instr[rd_ptr];
  assign f3 = i[14:12];
  assign f7 = i[31:25];
  always_ff @(posedge clk) if (push) begin
    fifo_instr[wr_ptr] <= if_instr;
    fifo_pc[wr_ptr] <= if_pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_comb begin
    d = '0;
    ill = 1'b0;
    d.pc = fifo_pc[rd_ptr];
    d.instr = i;
    d.waddr = i[11:7];
    d.rs1_addr = i[19:15];
    d.rs2_addr = i[24:20];
    d.branch_op = f3;
    d.mem_op = f3;
    d.csr_addr = i[31:20];
    case (i[6:0])
      7'b0110111: begin d.reg_wen = 1'b1; d.sel_imm = 1'b1; d.op1_zero = 1'b1; d.imm = {i[31:12], 12'b0}; end
      7'b0010111: begin d.reg_wen = 1'b1; d.sel_imm = 1'b1; d.op1_pc = 1'b1; d.imm = {i[31:12], 12'b0}; end
      7'b1101111: begin
        d.reg_wen = 1'b1; d.jal = 1'b1; d.op1_pc = 1'b1; d.op2_4 = 1'b1;
        d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1100111: begin
        d.reg_wen = 1'b1; d.jalr = 1'b1; d.rs1_rd = 1'b1; d.op1_pc = 1'b1; d.op2_4 = 1'b1;
        d.imm = {{20{i[31]}}, i[31:20]};
      end
      7'b1100011: begin
        d.br = 1'b1; d.rs1_rd = 1'b1; d.rs2_rd = 1'b1;
        d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        ill = f3[2:1] == 2'b01;
      end
      7'b0000011: begin
        d.reg_wen = 1'b1; d.rs1_rd = 1'b1; d.mem_rd = 1'b1; d.sel_imm = 1'b1;
        d.imm = {{20{i[31]}}, i[31:20]};
        ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      7'b0100011: begin
        d.rs1_rd = 1'b1; d.rs2_rd = 1'b1; d.mem_wr = 1'b1; d.sel_imm = 1'b1;
        d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        ill = f3 > 3'b010;
      end
      7'b0010011: begin
        d.reg_wen = 1'b1; d.rs1_rd = 1'b1; d.sel_imm = 1'b1;
        d.imm = {{20{i[31]}}, i[31:20]};
        d.alu_op = {f3 == 3'b101 && i[30], f3};
        ill = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      7'b0110011: begin
        d.reg_wen = 1'b1; d.rs1_rd = 1'b1; d.rs2_rd = 1'b1;
        d.alu_op = {i[30], f3};
        ill = (f7 != 7'b0 && f7 != 7'b0100000) || (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101);
`ifdef CORE_RV32M_EN
        if (f7 == 7'b0000001) begin
          d.md_instr = 1'b1; d.md_op = f3; d.alu_op = '0; ill = 1'b0;
        end
`endif
      end
      7'b0001111: ;
      7'b1110011: begin
        if (f3 == 3'b000) begin
          d.mret = i == 32'h30200073;
          ill = !d.mret;
        end else begin
          d.reg_wen = 1'b1; d.rs1_rd = !f3[2]; d.sel_imm = f3[2];
          d.imm = f3[2] ? {27'b0, i[19:15]} : '0;
          d.csr_rd = f3[1:0] != 2'b01 || i[11:7] != 5'd0;
          d.csr_wr_op = (f3[1] && i[19:15] == 5'd0) ? 2'b00 : f3[1:0];
        end
      end
      default: ill = 1'b1;
    endcase
    d.ill = ill;
    // illegal words must not leave architectural side effects behind
    if (ill) begin
      d.reg_wen = 1'b0; d.mem_rd = 1'b0; d.mem_wr = 1'b0; d.csr_wr_op = 2'b00;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (pop) begin
      q <= d;
      id_valid <= 1'b1;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end
  assign id_pc = q.pc;
  assign id_instr = q.instr;
  assign reg_wen = q.reg_wen;
  assign reg_rs1_rd = q.rs1_rd;
  assign reg_rs2_rd = q.rs2_rd;
  assign reg_waddr = q.waddr;
  assign reg_rs1_addr = q.rs1_addr;
  assign reg_rs2_addr = q.rs2_addr;
  assign imm_value = q.imm;
  assign alu_op = q.alu_op;
  assign sel_imm = q.sel_imm;
  assign op1_sel_zero = q.op1_zero;
  assign op1_sel_pc = q.op1_pc;
  assign op2_sel_4 = q.op2_4;
  assign br_instr = q.br;
  assign jal_instr = q.jal;
  assign jalr_instr = q.jalr;
  assign branch_op = q.branch_op;
  assign mem_op = q.mem_op;
  assign mem_rd = q.mem_rd;
  assign mem_wr = q.mem_wr;
  assign csr_rd = q.csr_rd;
  assign csr_wr_op = q.csr_wr_op;
  assign csr_addr = q.csr_addr;
  assign mret = q.mret;
  assign md_instr = q.md_instr;
  assign md_op = q.md_op;
  assign exc_ill_instr = q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plan cases plus randomized traffic checked against a queue-level reference model.
module tb_decode_stage;
  localparam int DEPTH = 2;
`ifdef CORE_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, if_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic if_ready, id_valid, reg_wen, reg_rs1_rd, reg_rs2_rd, sel_imm, op1_sel_zero, op1_sel_pc, op2_sel_4;
  logic br_instr, jal_instr, jalr_instr, mem_rd, mem_wr, csr_rd, mret, md_instr, exc_ill_instr;
  logic [31:0] id_pc, id_instr, imm_value;
  logic [4:0] reg_waddr, reg_rs1_addr, reg_rs2_addr;
  logic [3:0] alu_op;
  logic [2:0] branch_op, mem_op, md_op;
  logic [1:0] csr_wr_op;
  logic [11:0] csr_addr;
  always #5 clk = ~clk;
  decode_stage #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .reg_wen(reg_wen), .reg_rs1_rd(reg_rs1_rd),
    .reg_rs2_rd(reg_rs2_rd), .reg_waddr(reg_waddr), .reg_rs1_addr(reg_rs1_addr),
    .reg_rs2_addr(reg_rs2_addr), .imm_value(imm_value), .alu_op(alu_op), .sel_imm(sel_imm),
    .op1_sel_zero(op1_sel_zero), .op1_sel_pc(op1_sel_pc), .op2_sel_4(op2_sel_4),
    .br_instr(br_instr), .jal_instr(jal_instr), .jalr_instr(jalr_instr), .branch_op(branch_op),
    .mem_op(mem_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .csr_rd(csr_rd), .csr_wr_op(csr_wr_op),
    .csr_addr(csr_addr), .mret(mret), .md_instr(md_instr), .md_op(md_op),
    .exc_ill_instr(exc_ill_instr)
  );
  typedef struct packed {
    logic reg_wen, rs1_rd, rs2_rd;
    logic [4:0] waddr, rs1a, rs2a;
    logic [31:0] imm;
    logic [3:0] alu_op;
    logic sel_imm, op1_zero, op1_pc, op2_4, br, jal, jalr;
    logic [2:0] branch_op, mem_op;
    logic mem_rd, mem_wr, csr_rd;
    logic [1:0] csr_wr_op;
    logic [11:0] csr_addr;
    logic mret, md;
    logic [2:0] md_op;
    logic ill;
  } ctl_t;
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } item_t;
  item_t fq[$];
  item_t out_item;
  bit out_v = 1'b0;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic ctl_t obs_ctl();
    ctl_t c;
    c.reg_wen = reg_wen; c.rs1_rd = reg_rs1_rd; c.rs2_rd = reg_rs2_rd;
    c.waddr = reg_waddr; c.rs1a = reg_rs1_addr; c.rs2a = reg_rs2_addr;
    c.imm = imm_value; c.alu_op = alu_op; c.sel_imm = sel_imm; c.op1_zero = op1_sel_zero;
    c.op1_pc = op1_sel_pc; c.op2_4 = op2_sel_4; c.br = br_instr; c.jal = jal_instr;
    c.jalr = jalr_instr; c.branch_op = branch_op; c.mem_op = mem_op; c.mem_rd = mem_rd;
    c.mem_wr = mem_wr; c.csr_rd = csr_rd; c.csr_wr_op = csr_wr_op; c.csr_addr = csr_addr;
    c.mret = mret; c.md = md_instr; c.md_op = md_op; c.ill = exc_ill_instr;
    return c;
  endfunction
  // Reference decode: classify the word, check its legality against the allowed sets, then fill fields.
  function automatic ctl_t ref_decode(input logic [31:0] w);
    ctl_t e = '0;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic [31:0] imm_i = 32'($signed(w[31:20]));
    logic [31:0] imm_s = 32'($signed({w[31:25], w[11:7]}));
    logic [31:0] imm_b = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    logic [31:0] imm_j = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    logic [31:0] imm_u = w & 32'hFFFFF000;
    bit legal = 1'b1;
    e.waddr = w[11:7]; e.rs1a = w[19:15]; e.rs2a = w[24:20];
    e.branch_op = f3; e.mem_op = f3; e.csr_addr = w[31:20];
    if (op == 7'h37) begin
      e.reg_wen = 1; e.sel_imm = 1; e.op1_zero = 1; e.imm = imm_u;
    end else if (op == 7'h17) begin
      e.reg_wen = 1; e.sel_imm = 1; e.op1_pc = 1; e.imm = imm_u;
    end else if (op == 7'h6F) begin
      e.reg_wen = 1; e.jal = 1; e.op1_pc = 1; e.op2_4 = 1; e.imm = imm_j;
    end else if (op == 7'h67) begin
      e.reg_wen = 1; e.jalr = 1; e.rs1_rd = 1; e.op1_pc = 1; e.op2_4 = 1; e.imm = imm_i;
    end else if (op == 7'h63) begin
      e.br = 1; e.rs1_rd = 1; e.rs2_rd = 1; e.imm = imm_b;
      legal = f3 inside {0, 1, 4, 5, 6, 7};
    end else if (op == 7'h03) begin
      e.reg_wen = 1; e.rs1_rd = 1; e.mem_rd = 1; e.sel_imm = 1; e.imm = imm_i;
      legal = f3 inside {0, 1, 2, 4, 5};
    end else if (op == 7'h23) begin
      e.rs1_rd = 1; e.rs2_rd = 1; e.mem_wr = 1; e.sel_imm = 1; e.imm = imm_s;
      legal = f3 inside {0, 1, 2};
    end else if (op == 7'h13) begin
      e.reg_wen = 1; e.rs1_rd = 1; e.sel_imm = 1; e.imm = imm_i;
      e.alu_op = (f3 == 5) ? {w[30], f3} : {1'b0, f3};
      if (f3 == 1) legal = f7 == 0;
      if (f3 == 5) legal = f7 inside {7'h00, 7'h20};
    end else if (op == 7'h33) begin
      e.reg_wen = 1; e.rs1_rd = 1; e.rs2_rd = 1;
      if (M_EN && f7 == 7'h01) begin
        e.md = 1; e.md_op = f3;
      end else begin
        e.alu_op = {w[30], f3};
        legal = f7 == 0 || (f7 == 7'h20 && f3 inside {0, 5});
      end
    end else if (op == 7'h0F) begin
    end else if (op == 7'h73) begin
      if (f3 == 0) begin
        legal = w == 32'h30200073;
        e.mret = legal;
      end else begin
        e.reg_wen = 1; e.rs1_rd = !f3[2]; e.sel_imm = f3[2];
        e.imm = f3[2] ? 32'(w[19:15]) : 0;
        e.csr_rd = f3[1:0] != 1 || w[11:7] != 0;
        e.csr_wr_op = (f3[1] && w[19:15] == 0) ? 2'd0 : f3[1:0];
      end
    end else legal = 1'b0;
    if (!legal) begin
      e.ill = 1; e.reg_wen = 0; e.mem_rd = 0; e.mem_wr = 0; e.csr_wr_op = 0;
    end
    return e;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 19);
    if (k == 0) return 32'h30200073;
    if (k == 1) return w;
    w[6:0] = ops[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction
  task automatic check_state();
    check("if_ready", 256'(if_ready), 256'(fq.size() < DEPTH));
    check("id_valid", 256'(id_valid), 256'(out_v));
    if (out_v) begin
      check("id_pc", 256'(id_pc), 256'(out_item.pc));
      check("id_instr", 256'(id_instr), 256'(out_item.w));
      check("decode", 256'(obs_ctl()), 256'(ref_decode(out_item.w)));
    end
  endtask
  // Drive one cycle from just after a falling edge, advance the model, check at the next falling edge.
  task automatic cycle(input bit v, input logic [31:0] w, input logic [31:0] pc, input bit rdy, input bit fl);
    bit push, pop;
    if_valid = v; if_instr = w; if_pc = pc; id_ready = rdy; flush = fl;
    push = v && fq.size() < DEPTH;
    pop = fq.size() > 0 && (!out_v || rdy);
    if (fl) begin
      fq.delete();
      out_v = 1'b0;
    end else begin
      if (pop) begin
        out_item = fq.pop_front();
        out_v = 1'b1;
      end else if (rdy) out_v = 1'b0;
      if (push) fq.push_back('{w, pc});
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
    #1;
  endtask
  task automatic load_one(input logic [31:0] w, input logic [31:0] pc);
    cycle(1, w, pc, 1, 0);
    cycle(0, 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_if_ready", 256'(if_ready), 256'(0));
    check("rst_id_valid", 256'(id_valid), 256'(0));
    check("rst_ctrl", 256'(obs_ctl()), 256'(0));
    check("rst_id_pc", 256'(id_pc), 256'(0));
    rst = 1'b0;
    #1 check("if_ready_after_rst", 256'(if_ready), 256'(1));
    load_one(32'h002081B3, 32'h100);
    check("add_valid", 256'(id_valid), 256'(1));
    check("add_alu", 256'(alu_op), 256'(4'b0000));
    check("add_regs", 256'({reg_rs1_addr, reg_rs2_addr, reg_waddr, reg_wen}), 256'({5'd1, 5'd2, 5'd3, 1'b1}));
    check("add_pc", 256'(id_pc), 256'(32'h100));
    load_one(32'h123452B7, 32'h104);
    check("lui_imm", 256'(imm_value), 256'(32'h12345000));
    check("lui_fields", 256'({op1_sel_zero, reg_waddr}), 256'({1'b1, 5'd5}));
    load_one(32'h0020A423, 32'h108);
    check("sw_imm", 256'(imm_value), 256'(32'd8));
    check("sw_fields", 256'({mem_wr, mem_op, reg_wen}), 256'({1'b1, 3'b010, 1'b0}));
    load_one(32'h402081B3, 32'h10C);
    check("sub_legal", 256'({exc_ill_instr, alu_op}), 256'({1'b0, 4'b1000}));
    load_one(32'h402091B3, 32'h110);
    check("f7_20_sll_ill", 256'({exc_ill_instr, reg_wen}), 256'({1'b1, 1'b0}));
    load_one(32'h30200073, 32'h114);
    check("mret", 256'({mret, exc_ill_instr}), 256'({1'b1, 1'b0}));
    load_one(32'h022081B3, 32'h118);
    if (M_EN) check("mul_md", 256'({md_instr, md_op, exc_ill_instr}), 256'({1'b1, 3'b000, 1'b0}));
    else check("mul_ill", 256'({md_instr, exc_ill_instr}), 256'({1'b0, 1'b1}));
    // output held by the MUL; stream fetches until the buffer fills
    cycle(1, 32'h00100093, 32'h200, 0, 0);
    cycle(1, 32'h00200113, 32'h204, 0, 0);
    check("bp_full", 256'(if_ready), 256'(0));
    cycle(1, 32'h00300193, 32'h208, 0, 0);
    cycle(1, 32'h00300193, 32'h208, 1, 0);
    check("bp_release", 256'(if_ready), 256'(1));
    cycle(1, 32'h00300193, 32'h208, 1, 0);
    cycle(1, 32'h00400213, 32'h20C, 1, 0);
    repeat (4) cycle(0, 0, 0, 1, 0);
    load_one(32'h00500293, 32'h300);
    cycle(1, 32'h00600313, 32'h304, 0, 0);
    cycle(1, 32'h00700393, 32'h308, 0, 0);
    cycle(1, 32'h00800413, 32'h30C, 1, 1);
    check("flush_valid", 256'(id_valid), 256'(0));
    check("flush_ready", 256'(if_ready), 256'(1));
    repeat (2) cycle(0, 0, 0, 1, 0);
    check("flush_dropped", 256'(id_valid), 256'(0));
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        rst = 1'b1;
        #1;
        check("async_rst_ready", 256'(if_ready), 256'(0));
        check("async_rst_valid", 256'(id_valid), 256'(0));
        fq.delete();
        out_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_release_ready", 256'(if_ready), 256'(1));
      end
      cycle($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction-decode stage sitting between the fetch unit and the execute stage of the veriRISCV core. Instructions enter through a parametrised-depth FIFO buffer, are decoded from the buffer head, and are loaded into an output register that holds a full decoded bundle. The stage has valid/ready handshakes on both sides and a synchronous flush for branch/trap redirect. It also provides stricter illegal-instruction checking and optional RV32M decode.

## Interface
- `DEPTH`, 2: input buffer entries; power of 2, ≥2.
- `XLEN`, 32: data/PC width; only 32 is supported.
- `clk` input 1: core clock.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous discard of all buffered and output-held instructions.
- `if_valid` input 1: fetch offers an instruction.
- `if_ready` output 1: stage accepts; equals `!full && !rst`.
- `if_instr` input 32: instruction word.
- `if_pc` input 32: instruction PC.
- `id_valid` output 1: decoded bundle valid.
- `id_ready` input 1: execute consumes the bundle.
- `id_pc`, `id_instr` output 32 each: PC and raw word of the held instruction.
- `reg_wen`, `reg_rs1_rd`, `reg_rs2_rd` output 1 each.
- `reg_waddr`, `reg_rs1_addr`, `reg_rs2_addr` output 5 each.
- `imm_value` output 32.
- `alu_op` output 4: `{func7[5], func3}` encoding.
- `sel_imm`, `op1_sel_zero`, `op1_sel_pc`, `op2_sel_4` output 1 each.
- `br_instr`, `jal_instr`, `jalr_instr` output 1 each.
- `branch_op`, `mem_op` output 3 each: `func3`.
- `mem_rd`, `mem_wr` output 1 each.
- `csr_rd` output 1.
- `csr_wr_op` output 2.
- `csr_addr` output 12.
- `mret` output 1.
- `md_instr` output 1: multiply/divide instruction.
- `md_op` output 3: mul/div `func3`.
- `exc_ill_instr` output 1.

## Operation
- **Buffer.** Circular FIFO with read/write pointers of width `$clog2(DEPTH)` that wrap at DEPTH, plus a count of width `$clog2(DEPTH+1)`.
  - Push on `if_valid && if_ready`.
  - Pop when the head is non-empty and the output register is empty or being consumed (`!id_valid || id_ready`).
  - Push and pop in the same cycle leaves the count unchanged.
  - When full, `if_ready` is 0; there is no same-cycle pass-through.
- **Decode.** Combinational from the buffer head, following standard RV32I field extraction. Immediates:
  - I: `{{20{i[31]}},i[31:20]}`
  - S: `{{20{i[31]}},i[31:25],i[11:7]}`
  - B: `{{20{i[31]}},i[7],i[30:25],i[11:8],1'b0}`
  - U: `{i[31:12],12'b0}`
  - J: `{{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}`
  - CSR-immediate: `{27'b0,rs1}`
- **Control fields.**
  - CSR: `csr_rd = (func3[1:0]!=01) | (rd!=0)`; `csr_wr_op` is NOP when `func3[1]` and rs1=0.
  - `mret` asserts only for word 0x30200073.
- **Illegal instruction** (`exc_ill_instr` = 1, with `reg_wen`/`mem_rd`/`mem_wr`/`csr_wr_op` forced to 0):
  - Unknown opcode.
  - Load with func3 ∈ {011, 110, 111}.
  - Store with func3 > 010.
  - Branch with func3 ∈ {010, 011}.
  - R-type with func7 ∉ {0000000, 0100000}.
  - func7 = 0100000 with func3 ∉ {000, 101}.
  - Shift-immediate with imm[11:5] ∉ {0000000, 0100000}, or 0100000 on SLLI.
  - SYSTEM func3 = 000 other than MRET.
  - FENCE is **not** illegal: it decodes as a no-op.
- **Output register.** Loads the decoded head on pop. `id_valid` is set on pop, and cleared on `id_ready && !pop`.
- **Flush.**
  - Clears count, pointers and `id_valid` at the next edge.
  - Any push in the flush cycle is dropped.
  - `id_ready` is ignored in that cycle.
- **Reset.**
  - All outputs are 0 and the buffer is empty.
  - `if_ready` is 0 while `rst` is high and rises in the first cycle after deassertion.
  - Reset asserted mid-stream discards all contents.

## Timing
- Latency: an instruction accepted at edge N is visible with `id_valid`=1 after edge N+1, provided the output register is free.
- Throughput: one instruction per cycle with `id_ready` held high.
- With `id_ready`=0, the output stays stable and the buffer fills. `if_ready` falls in the cycle after the DEPTH-th accepted push.
- After a stall releases, the first pop frees an entry: `if_ready` is 1 in the following cycle.
- All decode outputs are registered; there are no combinational paths from `if_*` to `id_*`, or from `id_ready` to `if_ready`.

## Configuration
- **`CORE_RV32M_EN` defined:**
  - Opcode 0110011 with func7 = 0000001 decodes as multiply/divide.
  - Outputs: `md_instr`=1, `md_op`=func3, `reg_rs1_rd`=`reg_rs2_rd`=`reg_wen`=1, `alu_op`=ADD.
- **`CORE_RV32M_EN` undefined:**
  - The same encoding raises `exc_ill_instr`.
  - `md_instr` and `md_op` are tied to 0.

## Test plan
- **Single ADD.** Push 0x002081B3 at PC 0x100 → one cycle later `id_valid`=1, `alu_op`=0000, rs1=1, rs2=2, rd=3, `reg_wen`=1, `id_pc`=0x100.
- **LUI then SW.**
  - Push 0x123452B7 → `imm_value`=0x12345000, `op1_sel_zero`=1, rd=5.
  - Then push 0x0020A423 → `imm_value`=8, `mem_wr`=1, `mem_op`=010, `reg_wen`=0.
- **Backpressure.**
  - Hold `id_ready`=0 and stream 4 instructions with DEPTH=2 → `if_ready`=0 after the 2nd accepted push beyond the output register.
  - Release → instructions drain in order with no loss or duplication.
- **Flush.**
  - Flush with 2 entries buffered and `id_valid`=1 → next cycle `id_valid`=0 and `if_ready`=1.
  - A push in the flush cycle never appears at the output.
- **Illegal and MRET.**
  - 0x402081B3 (SUB) is legal; 0x402091B3 (func7 = 0100000, func3 = 001) gives `exc_ill_instr`=1.
  - 0x30200073 gives `mret`=1.
- **RV32M.** 0x022081B3 → with `CORE_RV32M_EN`, `md_instr`=1 and `md_op`=000; without it, `exc_ill_instr`=1.
